// File: rtl/slot_reels.sv
// Three-reel spin front end: reels cycle 0..VAL_MAX on a divided tick, ordered key presses
// stop them one by one, and a final key_3 press reseeds them from a free-running LFSR.
module slot_reels #(
    parameter int unsigned SPIN_DIV = 4,
    parameter int unsigned VAL_MAX  = 9,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_1,
    input  logic       key_2,
    input  logic       key_3,
    output logic [4:0] randomNum1,
    output logic [4:0] randomNum2,
    output logic [4:0] randomNum3,
    output logic [2:0] locked,
    output logic       round_done
);

    localparam int unsigned CW   = $clog2(SPIN_DIV);
    localparam logic [3:0]  VMAX = 4'(VAL_MAX);

    typedef enum logic [1:0] {StSpin, StStop1, StStop2, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [2:0]      sync1_q, sync2_q, prev_q;
    logic [2:0]      fall;
    logic            tick;
    logic            restart;
    logic [2:0]      step_en;
    logic [2:0][3:0] reel_q, reel_d;
    logic [2:0][3:0] slice;

    function automatic logic [3:0] reel_step(input logic [3:0] v);
        return (v == VMAX) ? 4'd0 : v + 4'd1;
    endfunction

    function automatic logic [3:0] fold(input logic [3:0] s);
        return (s > VMAX) ? s - 4'(VAL_MAX + 1) : s;
    endfunction

    // Falling edge of the synchronized (active-low) key, one pulse per press.
    assign fall  = prev_q & ~sync2_q;
    assign tick  = (cnt_q == CW'(SPIN_DIV - 1));
    assign slice = {lfsr_q[13:10], lfsr_q[8:5], lfsr_q[3:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StSpin;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StSpin:  if (fall[0]) state_d = StStop1;
            StStop1: if (fall[1]) state_d = StStop2;
            StStop2: if (fall[2]) state_d = StDone;
            StDone:  if (fall[2]) state_d = StSpin;
            default: state_d = StSpin;
        endcase
    end

    always_comb begin
        locked     = 3'b000;
        round_done = 1'b0;
        unique case (state_q)
            StSpin:  locked = 3'b000;
            StStop1: locked = 3'b001;
            StStop2: locked = 3'b011;
            StDone: begin
                locked     = 3'b111;
                round_done = 1'b1;
            end
            default: locked = 3'b000;
        endcase
    end

    always_comb begin
        cnt_d   = tick ? '0 : cnt_q + CW'(1);
        lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        restart = (state_q == StDone) && fall[2];
        // A reel stopping this cycle keeps its pre-tick value.
        step_en[0] = (state_q == StSpin) && !fall[0];
        step_en[1] = ((state_q == StSpin) || (state_q == StStop1))
                     && !((state_q == StStop1) && fall[1]);
        step_en[2] = (state_q != StDone) && !((state_q == StStop2) && fall[2]);
        for (int i = 0; i < 3; i++) begin
            reel_d[i] = reel_q[i];
            if (restart) begin
                reel_d[i] = fold(slice[i]);
            end else if (tick && step_en[i]) begin
                reel_d[i] = reel_step(reel_q[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            lfsr_q  <= SEED;
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
            prev_q  <= 3'b111;
            reel_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            sync1_q <= {key_3, key_2, key_1};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            reel_q  <= reel_d;
        end
    end

    assign randomNum1 = {1'b0, reel_q[0]};
    assign randomNum2 = {1'b0, reel_q[1]};
    assign randomNum3 = {1'b0, reel_q[2]};

endmodule

// File: tb/tb_slot_reels.sv
// Directed bench for slot_reels: reset, spin rate, ordered/out-of-order stops, held keys,
// tick coincidences, LFSR reseed and mid-round reset.
module tb_slot_reels;

    localparam int unsigned VMAX = 9;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_1, key_2, key_3;
    logic [4:0] randomNum1, randomNum2, randomNum3;
    logic [2:0] locked;
    logic       round_done;

    int checks   = 0;
    int failures = 0;

    logic [15:0] lv;
    logic [4:0]  e1, e2, e3;

    slot_reels #(
        .SPIN_DIV(4),
        .VAL_MAX (9),
        .SEED    (16'hACE1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key_1     (key_1),
        .key_2     (key_2),
        .key_3     (key_3),
        .randomNum1(randomNum1),
        .randomNum2(randomNum2),
        .randomNum3(randomNum3),
        .locked    (locked),
        .round_done(round_done)
    );

    always #5 clk = ~clk;

    // Reference Galois LFSR, taps 16,14,13,11, right shift, SEED 0xACE1.
    function automatic logic [15:0] lfsr_after(input int n);
        logic [15:0] v = 16'hACE1;
        for (int i = 0; i < n; i++) begin
            v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
        end
        return v;
    endfunction

    function automatic logic [4:0] fold_ref(input logic [3:0] s);
        return (s > 4'(VMAX)) ? 5'(s) - 5'(VMAX + 1) : 5'(s);
    endfunction

    function automatic logic [4:0] adv(input logic [4:0] v, input int n);
        return 5'((int'(v) + n) % (VMAX + 1));
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        key_1 = 1'b1;
        key_2 = 1'b1;
        key_3 = 1'b1;
        step(2);
        check("rst_r1", 16'(randomNum1), 16'd0);
        check("rst_r2", 16'(randomNum2), 16'd0);
        check("rst_r3", 16'(randomNum3), 16'd0);
        check("rst_locked", 16'(locked), 16'd0);
        check("rst_done", 16'(round_done), 16'd0);
        reset = 1'b0;

        // k counts edges since reset release; reel = (k/4) mod 10 while spinning.
        step(3);   // k=3
        check("spin_k3", 16'(randomNum1), 16'd0);
        step(1);   // k=4
        check("spin_k4", 16'(randomNum1), 16'd1);
        step(32);  // k=36
        check("spin_k36", 16'(randomNum1), 16'd9);
        step(4);   // k=40
        check("spin_wrap_r1", 16'(randomNum1), 16'd0);
        check("spin_wrap_r3", 16'(randomNum3), 16'd0);

        // Ordered stop.
        step(12);  // k=52, reel=3
        key_1 = 1'b0;
        step(2);   // k=54
        check("lat_k1_early", 16'(locked), 16'd0);
        step(1);   // k=55
        check("lock1", 16'(locked), 16'b001);
        check("lock1_r1", 16'(randomNum1), 16'd3);
        key_1 = 1'b1;
        step(1);   // k=56
        key_2 = 1'b0;
        step(3);   // k=59
        check("lock2", 16'(locked), 16'b011);
        check("lock2_r2", 16'(randomNum2), 16'd4);
        key_2 = 1'b1;
        key_3 = 1'b0;
        step(3);   // k=62
        check("lock3", 16'(locked), 16'b111);
        check("lock3_done", 16'(round_done), 16'd1);
        check("lock3_r3", 16'(randomNum3), 16'd5);
        key_3 = 1'b1;
        step(50);  // k=112
        check("frozen_r1", 16'(randomNum1), 16'd3);
        check("frozen_r2", 16'(randomNum2), 16'd4);
        check("frozen_r3", 16'(randomNum3), 16'd5);
        check("frozen_done", 16'(round_done), 16'd1);

        // Restart: reload edge is k=115, using the LFSR after 114 shifts.
        key_3 = 1'b0;
        step(2);   // k=114
        check("restart_early", 16'(locked), 16'b111);
        step(1);   // k=115
        key_3 = 1'b1;
        lv = lfsr_after(114);
        e1 = fold_ref(lv[3:0]);
        e2 = fold_ref(lv[8:5]);
        e3 = fold_ref(lv[13:10]);
        check("restart_locked", 16'(locked), 16'd0);
        check("restart_done", 16'(round_done), 16'd0);
        check("reload_r1", 16'(randomNum1), 16'(e1));
        check("reload_r2", 16'(randomNum2), 16'(e2));
        check("reload_r3", 16'(randomNum3), 16'(e3));
        step(1);   // k=116, tick
        check("reload_step_r1", 16'(randomNum1), 16'(adv(e1, 1)));

        // Out-of-order keys in SPIN.
        key_2 = 1'b0;
        key_3 = 1'b0;
        step(4);   // k=120
        check("ooo_locked", 16'(locked), 16'd0);
        check("ooo_r1", 16'(randomNum1), 16'(adv(e1, 2)));
        key_2 = 1'b1;
        key_3 = 1'b1;

        // Held key_1: one lock only.
        key_1 = 1'b0;
        step(3);   // k=123
        check("held_lock", 16'(locked), 16'b001);
        check("held_r1", 16'(randomNum1), 16'(adv(e1, 2)));
        step(37);  // k=160
        check("held_still", 16'(locked), 16'b001);
        key_1 = 1'b1;
        step(2);   // k=162
        key_1 = 1'b0;
        key_2 = 1'b0;
        step(3);   // k=165
        check("both_locked", 16'(locked), 16'b011);
        check("both_r2", 16'(randomNum2), 16'(adv(e2, 13)));
        check("both_r1", 16'(randomNum1), 16'(adv(e1, 2)));
        key_1 = 1'b1;
        key_2 = 1'b1;
        step(3);   // k=168
        check("stop2_r3", 16'(randomNum3), 16'(adv(e3, 14)));

        // Reset in STOP2.
        reset = 1'b1;
        step(1);
        check("midrst_r1", 16'(randomNum1), 16'd0);
        check("midrst_r2", 16'(randomNum2), 16'd0);
        check("midrst_r3", 16'(randomNum3), 16'd0);
        check("midrst_locked", 16'(locked), 16'd0);
        check("midrst_done", 16'(round_done), 16'd0);
        reset = 1'b0;

        // Tick coincidence: fall pulse in the cycle before edge 40 (reel 9 -> 0 tick).
        step(37);  // k=37
        key_1 = 1'b0;
        step(2);   // k=39
        check("tc_pre_r2", 16'(randomNum2), 16'd9);
        step(1);   // k=40
        check("tc_locked", 16'(locked), 16'b001);
        check("tc_r1", 16'(randomNum1), 16'd9);
        check("tc_r2", 16'(randomNum2), 16'd0);
        check("tc_r3", 16'(randomNum3), 16'd0);
        key_1 = 1'b1;
        step(1);   // k=41
        key_2 = 1'b0;
        step(3);   // k=44
        check("tc2_r2", 16'(randomNum2), 16'd0);
        key_2 = 1'b1;
        key_3 = 1'b0;
        step(3);   // k=47
        check("tc3_locked", 16'(locked), 16'b111);
        check("tc3_r3", 16'(randomNum3), 16'd1);
        key_3 = 1'b1;

        // Restart on a tick edge (k=52): reload wins, no step.
        step(2);   // k=49
        key_3 = 1'b0;
        step(2);   // k=51
        check("rt_early", 16'(locked), 16'b111);
        step(1);   // k=52
        key_3 = 1'b1;
        lv = lfsr_after(51);
        check("rt_locked", 16'(locked), 16'd0);
        check("rt_r1", 16'(randomNum1), 16'(fold_ref(lv[3:0])));
        check("rt_r2", 16'(randomNum2), 16'(fold_ref(lv[8:5])));
        check("rt_r3", 16'(randomNum3), 16'(fold_ref(lv[13:10])));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/slot_reels.md
Name: slot_reels

Overview:
- Reel-spin front end that drives the three 5-bit reel values consumed by the slots FSM on randomNum1..randomNum3.
- Three reels cycle through 0..VAL_MAX at a divided tick rate.
- Each player key press stops one reel, in order; the stopped value is frozen on the output.
- After all reels stop, a key_3 press reseeds the reels from a free-running LFSR and restarts spinning.

Parameters:
- SPIN_DIV, 4, clk cycles per reel step; valid for any value >= 2. Board builds set 2500000.
- VAL_MAX, 9, highest reel value; legal range 8..15.
- SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- key_1  in  1  raw KEY3, active-low; stops reel 1
- key_2  in  1  raw KEY2, active-low; stops reel 2
- key_3  in  1  raw KEY1, active-low; stops reel 3, and restarts when all reels are stopped
- randomNum1  out  5  reel 1 value, registered
- randomNum2  out  5  reel 2 value, registered
- randomNum3  out  5  reel 3 value, registered
- locked  out  3  bit i-1 high when reel i is stopped
- round_done  out  1  high while all three reels are stopped

Behaviour:
- Reset (synchronous, active-high, checked at the rising edge of clk) sets:
  - randomNum1..3 = 0, locked = 0, round_done = 0
  - state = SPIN, tick counter = 0, LFSR = SEED
  - synchronizer flops = 1 (key released)
- Reset has priority over every other event, including reset asserted mid-round.
- LFSR: 16-bit Galois, taps 16,14,13,11. Shifts every clk cycle in all states, never stalls.
- Tick counter: counts 0..SPIN_DIV-1 and wraps to 0. tick = 1 for one cycle when the count equals SPIN_DIV-1.
- Reel step on tick: next = (cur == VAL_MAX) ? 0 : cur + 1. Bit 4 of every reel output is always 0.
- Key path:
  - Each key passes through a 2-flop synchronizer, then a falling-edge detector.
  - The fall pulse is high for exactly 1 cycle, 2 cycles after the raw key is first sampled low.
  - A key held low produces one pulse only.
- Lock register and output update at the rising edge following the fall pulse.
- States and transitions:
  - SPIN: all reels step on tick. fall1 -> STOP1, reel 1 freezes, locked = 3'b001.
  - STOP1: reels 2 and 3 step. fall2 -> STOP2, locked = 3'b011.
  - STOP2: reel 3 steps. fall3 -> DONE, locked = 3'b111, round_done = 1.
  - DONE: no reel steps. fall3 -> SPIN:
    - locked = 0, round_done = 0
    - each reel reloads with fold(slice), where slice_1 = LFSR[3:0], slice_2 = LFSR[8:5], slice_3 = LFSR[13:10]
    - fold(s) = (s > VAL_MAX) ? s - (VAL_MAX+1) : s
- Out-of-order keys are ignored and have no side effect:
  - key_2 or key_3 in SPIN
  - key_1 in STOP1 or later
  - key_1 or key_2 in DONE
- Simultaneous events:
  - Fall pulse and tick in the same cycle: the stopping reel freezes at its pre-tick value; still-spinning reels advance.
  - Several fall pulses in one cycle: only the pulse valid for the current state acts; one transition per cycle at most.
  - Restart and tick in the same cycle: the reload wins; no step is applied that cycle.
- Reels never exceed VAL_MAX in any state.

Test Plan:
- Reset check: assert reset for 2 cycles with keys high -> outputs all 0, locked = 0, round_done = 0; with SPIN_DIV = 4, randomNum1 steps 0,1,2,…,9,0 every 4 cycles.
- Ordered stop:
  - Pull key_1 low while reel 1 = 3 -> 3 cycles later locked = 001 and randomNum1 holds 3.
  - key_2, then key_3 -> locked = 011, then 111; round_done = 1; all values frozen for 50 cycles.
- Out-of-order keys: in SPIN, pulse key_3 and key_2 -> locked stays 000 and reels keep stepping; then key_1 -> locked = 001.
- Held key and bounce: key_1 held low for 40 cycles -> exactly one lock. Release, then press key_2 simultaneously with key_1 while in STOP1 -> only reel 2 locks.
- Tick coincidence: time the key_1 fall pulse to the tick cycle with reel 1 = 9 -> randomNum1 frozen at 9, not 0; reels 2 and 3 advance.
- Restart and reset:
  - In DONE, press key_3 -> locked = 0 and every reel <= VAL_MAX.
  - With SEED = 16'hACE1 and restart at a known cycle, reloaded values match the reference LFSR model.
  - Assert reset in STOP2 -> all outputs return to reset values on the next edge.
